// File: rtl/data_mem_responder_pkg.sv
// Shared types and the byte-enable legality helper for the data-memory responder.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {Idle, Wait, Done} resp_state_t;

  // Request flags captured in Idle and held for the whole handshake
  typedef struct packed {
    logic is_rd;
    logic is_wr;
    logic legal;
  } mem_req_t;

  // Legal iff byte_en is a run of 2^k ones starting at lane offset, with offset aligned to 2^k.
  function automatic logic byte_en_legal(input int lanes, input logic [2:0] offset,
                                         input logic [7:0] byte_en);
    logic ok;
    int   off;
    int   mask;
    ok  = 1'b0;
    off = int'(offset);
    for (int sz = 1; sz <= lanes; sz = sz * 2) begin
      mask = ((1 << sz) - 1) << off;
      if ((off % sz) == 0 && (off + sz) <= lanes && byte_en == mask[7:0]) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// DEPTH x DATA_SIZE single-port RAM, synchronous read, per-byte-lane write enables.
module byte_enable_ram #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 1024
) (
  input  logic                       clock,
  input  logic                       we,
  input  logic [DATA_SIZE/8-1:0]     be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_SIZE-1:0]       wdata,
  output logic [DATA_SIZE-1:0]       rdata
);
  localparam int LANES = DATA_SIZE / 8;

  logic [LANES-1:0][7:0] wd_l;
  logic [LANES-1:0][7:0] rd_l;

  assign wd_l  = wdata;
  assign rdata = rd_l;

  // One independent byte array per lane keeps each lane single-driven
  for (genvar i = 0; i < LANES; i++) begin : gen_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clock) begin
      if (we && be[i]) mem[addr] <= wd_l[i];
      q <= mem[addr];
    end

    assign rd_l[i] = q;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: LATENCY wait states, mem_busy stall, byte-enable RAM.
// Optional misalignment rejection when MISALIGN_CHECK_EN is defined.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mem_rd_en,
  input  logic                   mem_wr_en,
  input  logic [DATA_SIZE/8-1:0] mem_byte_en,
  input  logic [DATA_SIZE-1:0]   data_mem_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   misaligned
);
  localparam int LANES = DATA_SIZE / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(LATENCY + 1);

  resp_state_t          state_q;
  logic [CW-1:0]        cnt_q;
  mem_req_t             req_q;
  logic [AW-1:0]        word_q;
  logic [LANES-1:0]     be_q;
  logic [DATA_SIZE-1:0] wd_q;

  logic                 req;
  logic                 legal_now;
  logic [AW-1:0]        word_now;
  logic [AW-1:0]        ram_addr;
  logic                 ram_we;
  logic [DATA_SIZE-1:0] ram_rdata;
  logic                 unused_addr;

  assign req         = mem_rd_en | mem_wr_en;
  assign word_now    = data_mem_addr[OFF+AW-1:OFF];
  assign unused_addr = ^data_mem_addr;

`ifdef MISALIGN_CHECK_EN
  assign legal_now  = byte_en_legal(LANES, 3'(data_mem_addr[OFF-1:0]), 8'(mem_byte_en));
  assign misaligned = (state_q == Done) && !req_q.legal;
`else
  assign legal_now  = 1'b1;
  assign misaligned = 1'b0;
`endif

  assign mem_busy = ((state_q == Idle) && req) || (state_q == Wait);

  // Live address in Idle so the synchronous read is already valid in the first Wait cycle
  assign ram_addr = (state_q == Idle) ? word_now : word_q;
  assign ram_we   = (state_q == Done) && req_q.is_wr && req_q.legal && !reset;

  byte_enable_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .be    (be_q),
    .addr  (ram_addr),
    .wdata (wd_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Idle;
      cnt_q   <= '0;
      req_q   <= '0;
      word_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_data <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (req) begin
            state_q     <= Wait;
            cnt_q       <= CW'(LATENCY - 1);
            req_q.is_rd <= mem_rd_en & ~mem_wr_en;
            req_q.is_wr <= mem_wr_en;
            req_q.legal <= legal_now;
            word_q      <= word_now;
            be_q        <= mem_byte_en;
            wd_q        <= wr_data;
          end
        end
        Wait: begin
          if (cnt_q == '0) begin
            state_q <= Done;
            if (req_q.is_rd && req_q.legal) rd_data <= ram_rdata;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        Done:    state_q <= Idle;
        default: state_q <= Idle;
      endcase
    end
  end

endmodule
